sync_fifo_fwft_status: RTL and testbench

//  Synchronous FWFT FIFO with clear: head word always valid on o_rd_data while !o_empty.
//  Any DEPTH >= 2, power of two not required; internal pointers wrap explicitly.

---
 rtl/sync_fifo_fwft_status_pkg.sv | 15 +
 rtl/sync_fifo_fwft_status_sdp_ram.sv | 26 ++
 rtl/sync_fifo_fwft_status.sv | 106 ++++++++++
 tb/tb_sync_fifo_fwft_status.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_fwft_status_pkg.sv
// Shared types and helpers for the FWFT status FIFO.
//   fifo_flags_t : sticky error flags (overflow, underflow)
//   ptr_inc      : pointer advance with explicit wrap at depth-1 (any depth)
package sync_fifo_fwft_status_pkg;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_flags_t;

  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft_status_sdp_ram.sv
// Simple dual-port RAM, DEPTH x DATA_WIDTH, any depth.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read port; rdata registered and held while re is low
module sync_fifo_fwft_status_sdp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_fwft_status.sv
// First-word-fall-through synchronous FIFO with occupancy, runtime almost
// thresholds and sticky overflow/underflow flags.
//   clk, rst (sync, active-high), i_clr (sync flush)
//   i_wr_en/i_wr_data, o_full    : write side; a write while full is accepted
//                                  only if a read happens in the same cycle
//   i_rd_en/o_rd_data, o_empty   : read side; head word shown while !o_empty
//   o_count                      : occupancy 0..DEPTH
//   i_afull_thresh/o_almost_full : o_count >= threshold
//   i_aempty_thresh/o_almost_empty : o_count <= threshold
//   o_overflow/o_underflow       : sticky until rst or i_clr
module sync_fifo_fwft_status
  import sync_fifo_fwft_status_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_full,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_empty,
  output logic [CW-1:0]         o_count,
  input  logic [CW-1:0]         i_afull_thresh,
  input  logic [CW-1:0]         i_aempty_thresh,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]         count;
  fifo_flags_t           flags;
  logic [DATA_WIDTH-1:0] bypass_q, ram_q;
  logic                  sel_bypass;
  logic                  rd_ok, wr_ok, bypass_load, ram_re, ram_we;

  assign o_empty = (count == '0);
  assign o_full  = (count == CW'(DEPTH));
  assign rd_ok   = i_rd_en & ~o_empty;
  assign wr_ok   = i_wr_en & (~o_full | rd_ok);

  assign wr_ptr_nxt = AW'(ptr_inc(32'(wr_ptr), 32'(DEPTH)));
  assign rd_ptr_nxt = AW'(ptr_inc(32'(rd_ptr), 32'(DEPTH)));

  // The incoming word becomes the head directly when nothing else will be
  // ahead of it next cycle; otherwise the head is prefetched from RAM.
  assign bypass_load = wr_ok & (o_empty | ((count == CW'(1)) & rd_ok));
  assign ram_re      = ~rst & ~i_clr & rd_ok & (count >= CW'(2));
  assign ram_we      = ~rst & ~i_clr & wr_ok;

  sync_fifo_fwft_status_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (i_wr_data),
    .re    (ram_re),
    .raddr (rd_ptr_nxt),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      flags      <= '0;
      sel_bypass <= 1'b1;
      bypass_q   <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr_nxt;
      if (rd_ok) rd_ptr <= rd_ptr_nxt;
      if (wr_ok && !rd_ok)      count <= count + CW'(1);
      else if (rd_ok && !wr_ok) count <= count - CW'(1);
      if (i_wr_en && !wr_ok) flags.overflow  <= 1'b1;
      if (i_rd_en && o_empty) flags.underflow <= 1'b1;
      if (bypass_load) begin
        bypass_q   <= i_wr_data;
        sel_bypass <= 1'b1;
      end else if (ram_re) begin
        sel_bypass <= 1'b0;
      end
    end
  end

  // Both sources and the select are registers, so the head has no
  // combinational path from the write data or read enable.
  assign o_rd_data      = sel_bypass ? bypass_q : ram_q;
  assign o_count        = count;
  assign o_almost_full  = (count >= i_afull_thresh);
  assign o_almost_empty = (count <= i_aempty_thresh);
  assign o_overflow     = flags.overflow;
  assign o_underflow    = flags.underflow;

endmodule

// File: tb/tb_sync_fifo_fwft_status.sv
module tb_sync_fifo_fwft_status;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, i_clr, i_wr_en, i_rd_en;
  logic [DW-1:0] i_wr_data;
  logic [CW-1:0] i_afull_thresh, i_aempty_thresh;
  logic          o_full, o_empty, o_almost_full, o_almost_empty, o_overflow, o_underflow;
  logic [DW-1:0] o_rd_data;
  logic [CW-1:0] o_count;

  int vectors    = 0;
  int miscompares = 0;

  logic [DW-1:0] q[$];
  logic          m_ovf, m_udf;

  always #5 clk = ~clk;

  sync_fifo_fwft_status #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_clr           (i_clr),
    .i_wr_en         (i_wr_en),
    .i_wr_data       (i_wr_data),
    .o_full          (o_full),
    .i_rd_en         (i_rd_en),
    .o_rd_data       (o_rd_data),
    .o_empty         (o_empty),
    .o_count         (o_count),
    .i_afull_thresh  (i_afull_thresh),
    .i_aempty_thresh (i_aempty_thresh),
    .o_almost_full   (o_almost_full),
    .o_almost_empty  (o_almost_empty),
    .o_overflow      (o_overflow),
    .o_underflow     (o_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a queue of words plus two sticky bits, updated from the
  // inputs the DUT sampled on the edge just taken.
  task automatic model_update(input logic r, input logic c, input logic wr,
                              input logic [DW-1:0] d, input logic rd);
    bit rdo, wro;
    if (r || c) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      return;
    end
    rdo = rd && (q.size() > 0);
    wro = wr && ((q.size() < DEPTH) || rdo);
    if (rd && q.size() == 0) m_udf = 1'b1;
    if (wr && !wro) m_ovf = 1'b1;
    if (rdo) void'(q.pop_front());
    if (wro) q.push_back(d);
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count", 32'(o_count), 32'(n));
    chk("empty", 32'(o_empty), 32'(n == 0));
    chk("full", 32'(o_full), 32'(n == DEPTH));
    chk("almost_full", 32'(o_almost_full), 32'(n >= int'(i_afull_thresh)));
    chk("almost_empty", 32'(o_almost_empty), 32'(n <= int'(i_aempty_thresh)));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
    chk("underflow", 32'(o_underflow), 32'(m_udf));
    if (n > 0) chk("rd_data", 32'(o_rd_data), 32'(q[0]));
  endtask

  task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd, input logic c);
    i_wr_en   = wr;
    i_wr_data = d;
    i_rd_en   = rd;
    i_clr     = c;
    @(posedge clk);
    model_update(rst, c, wr, d, rd);
    #1;
    check_all();
  endtask

  task automatic check_reset_values();
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    chk("rst_udf", 32'(o_underflow), 32'd0);
    chk("rst_rd_data", 32'(o_rd_data), 32'd0);
  endtask

  initial begin
    rst = 1'b1; i_clr = 1'b0; i_wr_en = 1'b0; i_rd_en = 1'b0; i_wr_data = '0;
    i_afull_thresh = 3'd4; i_aempty_thresh = 3'd1;
    m_ovf = 1'b0; m_udf = 1'b0;

    // Reset
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b0);
    check_reset_values();
    rst = 1'b0;

    // T1: fill, overflow, drain with pointer wrap
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
    chk("t1_full", 32'(o_full), 32'd1);
    step(1'b1, 8'h16, 1'b0, 1'b0);
    chk("t1_ovf", 32'(o_overflow), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t1_order", 32'(o_rd_data), 32'(8'h11 + i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // T2: write-to-empty latency
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("t2_head", 32'(o_rd_data), 32'h A5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2_empty", 32'(o_empty), 32'd1);

    // T3: count 1, read and write together
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b1, 1'b0);
    chk("t3_head", 32'(o_rd_data), 32'h02);
    chk("t3_count", 32'(o_count), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // T4: full, read and write together
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("t4_count", 32'(o_count), 32'd5);
    chk("t4_ovf", 32'(o_overflow), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_last", 32'(o_rd_data), 32'h77);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // T5: underflow then clear; rd/wr in clear cycle ignored
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_udf", 32'(o_underflow), 32'd1);
    step(1'b1, 8'h55, 1'b1, 1'b1);
    chk("t5_clr_udf", 32'(o_underflow), 32'd0);
    chk("t5_clr_empty", 32'(o_empty), 32'd1);

    // T6: almost thresholds while filling, then reset mid-fill
    i_afull_thresh = 3'd4; i_aempty_thresh = 3'd1;
    for (int i = 0; i < 6; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("t6_afull", 32'(o_almost_full), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    check_reset_values();
    rst = 1'b0;

    // Threshold above DEPTH never asserts almost-full
    i_afull_thresh = 3'd6;
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    chk("afull_above_depth", 32'(o_almost_full), 32'd0);

    // Randomized traffic with changing thresholds
    for (int i = 0; i < 400; i++) begin
      i_afull_thresh  = 3'($urandom_range(0, 7));
      i_aempty_thresh = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 199) == 0);
      step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 3));
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
